pwm_burst_mc: RTL and testbench
===============================

# pwm_burst_mc

Multi-channel successor to the single-channel pulse-train generator in the PWM/pulse subsystem. Each of `_CH_NUM` independent channels emits a burst of `N` pulses (or a continuous train), each `W` clocks active followed by `G` clocks idle. Pulse parameters are shadow-latched at start, so register writes mid-burst have no effect. An optional per-channel start delay is compiled in by macro. Sits between the control register bank and the output pin mux; one instance replaces `_CH_NUM` single-channel generators.

## Interface
- `_RAM_WIDTH`, 32, width of every counter and parameter field
- `_CH_NUM`, 4, number of independent channels (>=1)

Ports (channel i occupies bits `[i]`, or `[i*_RAM_WIDTH +: _RAM_WIDTH]` for bus fields):
- `io_clk`  in  1  sole clock; all logic on the rising edge
- `io_rst`  in  1  asynchronous, active-high reset
- `io_en`  in  `_CH_NUM`  per-channel enable; rising edge starts, low aborts
- `io_defaultLevel`  in  `_CH_NUM`  idle level; active level is its inverse
- `io_pulseWidth`  in  `_CH_NUM*_RAM_WIDTH`  W, active clocks per pulse
- `io_unaccessWidth`  in  `_CH_NUM*_RAM_WIDTH`  G, idle clocks after each pulse
- `io_pusle_times`  in  `_CH_NUM*_RAM_WIDTH`  N, pulses per burst; 0 = continuous
- `io_trigDelay`  in  `_CH_NUM*_RAM_WIDTH`  D, clocks from start to first pulse (used only with macro)
- `io_pulseOut`  out  `_CH_NUM`  registered pulse output
- `pulse_valid`  out  `_CH_NUM`  one-cycle strobe: burst completed or aborted
- `pulse_busy`  out  `_CH_NUM`  high while a burst is in progress

## Operation
- Reset: `io_pulseOut`, `pulse_valid`, `pulse_busy`, all counters, all shadows and the registered enable (`en_d`) = 0; FSM = IDLE.
- Per-channel FSM states: IDLE, DELAY, ACTIVE, GAP. Channels share no state.
- Start condition: `io_en[i] & ~en_d[i]` at a clock edge. At that edge W, G, N and D are latched into shadows and `pulse_busy` is set.
  - If W==0: no pulse is emitted. `pulse_valid` strobes on the next cycle and `pulse_busy` stays 0.
  - If W!=0: go to DELAY when D!=0 (macro on), otherwise go to ACTIVE.
- DELAY: count D clocks, then go to ACTIVE.
- ACTIVE: output is at the active level for exactly W clocks.
  - At the end of the pulse, decrement the remaining count (burst mode only), then go to GAP.
  - If G==0, the next pulse follows back-to-back, so the output stays continuously active.
- GAP: output is at the default level for G clocks. At the end of GAP:
  - remaining>0, or continuous mode: go to ACTIVE;
  - otherwise: go to IDLE, pulse `pulse_valid` for 1 cycle, clear `pulse_busy`.
- A trailing gap always runs after the final pulse.
- Abort: `io_en[i]` sampled low while `pulse_busy`:
  - next edge: FSM goes to IDLE, output returns to `io_defaultLevel`, `pulse_busy` clears, `pulse_valid` strobes 1 cycle;
  - abort takes priority over every other transition.
- `io_en` falling while IDLE produces no strobe.
- `io_en` held high after completion: no restart. A new rising edge is required.
- IDLE output follows the live `io_defaultLevel[i]`, registered. ACTIVE/GAP/DELAY use the latched default level.
- Arithmetic:
  - all counters are unsigned `_RAM_WIDTH`, no wrap; a counter loaded with `2^_RAM_WIDTH-1` is valid;
  - the remaining-count decrement never underflows, because continuous mode (N==0) never decrements.

## Timing
- If `io_en` is first sampled high at edge k, the first active output cycle is k+1 to k+1+W (no delay), or k+1+D to k+1+D+W (delay).
- Pulse period = W+G clocks exactly.
- Burst duration from edge k to the `pulse_valid` cycle = D + N·(W+G) clocks; `pulse_valid` is high in cycle k+D+N(W+G)+1.
- `pulse_busy` is high from cycle k+1 through the cycle before `pulse_valid`.
- Abort latency: 1 clock from `io_en` sampled low to output at default level.
- A restart edge arriving in the same cycle that `pulse_valid` is asserted is honoured.

## Configuration
- `PWM_TRIG_DELAY_EN` defined: DELAY state and D counter are present and `io_trigDelay` is honoured; D==0 skips DELAY.
- Undefined: DELAY state and D counter are not synthesised, `io_trigDelay` is ignored, and the first pulse always starts at k+1.

## Test plan
- Ch0, default 0, W=3, G=2, N=4, `io_en` rise at edge 10 -> output high 11–13, 16–18, 21–23, 26–28; `pulse_valid` in cycle 31 only.
- Ch1, default 1, W=1, G=0, N=0 -> output low continuously from k+1. `io_en` low at edge 50 -> output high at 51, `pulse_valid` strobe at 51.
- W=0, N=5 -> output never leaves default level; single `pulse_valid`; `pulse_busy` stays 0.
- Macro on, D=5, W=2, G=1, N=1, rise at edge 0 -> first active cycle 6–7, `pulse_valid` in cycle 9. Macro off, same stimulus -> active 1–2, `pulse_valid` in cycle 4.
- Change `io_pulseWidth` from 3 to 7 mid-burst -> all pulses remain 3 clocks. Two channels started 2 cycles apart with different W/G -> waveforms independent and exact.
- Assert `io_rst` mid-ACTIVE -> all outputs 0 immediately. After release, IDLE output follows default level, and no strobe occurs until a new `io_en` edge.

Source files
------------

// File: rtl/pwm_burst_mc_if.sv
// Parameter/status bundle between the control register bank (master) and pwm_burst_mc (slave).
interface pwm_burst_mc_if #(
    parameter int _RAM_WIDTH = 32,
    parameter int _CH_NUM    = 4
);
    logic [_CH_NUM-1:0]            io_en;
    logic [_CH_NUM-1:0]            io_defaultLevel;
    logic [_CH_NUM*_RAM_WIDTH-1:0] io_pulseWidth;
    logic [_CH_NUM*_RAM_WIDTH-1:0] io_unaccessWidth;
    logic [_CH_NUM*_RAM_WIDTH-1:0] io_pusle_times;
    logic [_CH_NUM*_RAM_WIDTH-1:0] io_trigDelay;
    logic [_CH_NUM-1:0]            io_pulseOut;
    logic [_CH_NUM-1:0]            pulse_valid;
    logic [_CH_NUM-1:0]            pulse_busy;

    modport master (
        output io_en, io_defaultLevel, io_pulseWidth, io_unaccessWidth, io_pusle_times, io_trigDelay,
        input  io_pulseOut, pulse_valid, pulse_busy
    );

    modport slave (
        input  io_en, io_defaultLevel, io_pulseWidth, io_unaccessWidth, io_pusle_times, io_trigDelay,
        output io_pulseOut, pulse_valid, pulse_busy
    );
endinterface

// File: rtl/pwm_burst_mc.sv
// Multi-channel burst pulse generator: per channel, N pulses (N==0: continuous) of W active / G idle clocks.
// Define PWM_TRIG_DELAY_EN to compile in the per-channel start delay (DELAY state, io_trigDelay).
module pwm_burst_mc #(
    parameter int _RAM_WIDTH = 32,
    parameter int _CH_NUM    = 4
) (
    input  logic          io_clk,
    input  logic          io_rst,
    pwm_burst_mc_if.slave bus
);
    localparam int RW = _RAM_WIDTH;
    localparam logic [RW-1:0] ZERO = {RW{1'b0}};
    localparam logic [RW-1:0] ONE  = {{(RW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_ACTIVE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    for (genvar g = 0; g < _CH_NUM; g++) begin : g_ch
        state_t        r_state, w_state;
        logic [RW-1:0] r_cnt, w_cnt;
        logic [RW-1:0] r_rem, w_rem;
        logic [RW-1:0] r_w, w_w;
        logic [RW-1:0] r_g, w_g;
        logic          r_cont, w_cont;
        logic          r_lvl, w_lvl;
        logic          r_out, w_out;
        logic          r_valid, w_valid;
        logic          r_busy;
        logic          r_en_d;
        logic [RW-1:0] w_in_w, w_in_g, w_in_n, w_rem_dec;
        logic          w_def, w_start, w_abort;
`ifdef PWM_TRIG_DELAY_EN
        logic [RW-1:0] w_in_d;
        assign w_in_d = bus.io_trigDelay[g*RW +: RW];
`endif

        assign w_in_w    = bus.io_pulseWidth[g*RW +: RW];
        assign w_in_g    = bus.io_unaccessWidth[g*RW +: RW];
        assign w_in_n    = bus.io_pusle_times[g*RW +: RW];
        assign w_def     = bus.io_defaultLevel[g];
        assign w_start   = bus.io_en[g] & ~r_en_d;
        assign w_abort   = (r_state != S_IDLE) & ~bus.io_en[g];
        // Continuous mode never counts down, so the burst count cannot underflow
        assign w_rem_dec = (r_cont || (r_rem == ZERO)) ? r_rem : (r_rem - ONE);

        // Next-state and next-output decode; the output register is loaded from this
        always_comb begin
            w_state = r_state;
            w_cnt   = r_cnt;
            w_rem   = r_rem;
            w_w     = r_w;
            w_g     = r_g;
            w_cont  = r_cont;
            w_lvl   = r_lvl;
            w_out   = r_out;
            w_valid = 1'b0;
            case (r_state)
                S_IDLE: begin
                    w_out = w_def;
                    if (w_start) begin
                        w_w    = w_in_w;
                        w_g    = w_in_g;
                        w_rem  = w_in_n;
                        w_cont = (w_in_n == ZERO);
                        w_lvl  = w_def;
                        if (w_in_w == ZERO) begin
                            w_valid = 1'b1;
                        end
`ifdef PWM_TRIG_DELAY_EN
                        else if (w_in_d != ZERO) begin
                            w_state = S_DELAY;
                            w_cnt   = w_in_d - ONE;
                        end
`endif
                        else begin
                            w_state = S_ACTIVE;
                            w_cnt   = w_in_w - ONE;
                            w_out   = ~w_def;
                        end
                    end else begin
                        w_cnt = ZERO;
                    end
                end
`ifdef PWM_TRIG_DELAY_EN
                S_DELAY: begin
                    if (r_cnt == ZERO) begin
                        w_state = S_ACTIVE;
                        w_cnt   = r_w - ONE;
                        w_out   = ~r_lvl;
                    end else begin
                        w_cnt = r_cnt - ONE;
                        w_out = r_lvl;
                    end
                end
`endif
                S_ACTIVE: begin
                    if (r_cnt != ZERO) begin
                        w_cnt = r_cnt - ONE;
                        w_out = ~r_lvl;
                    end else begin
                        w_rem = w_rem_dec;
                        if (r_g != ZERO) begin
                            w_state = S_GAP;
                            w_cnt   = r_g - ONE;
                            w_out   = r_lvl;
                        end else if (r_cont || (w_rem_dec != ZERO)) begin
                            // Zero-length gap: next pulse starts back-to-back
                            w_cnt = r_w - ONE;
                            w_out = ~r_lvl;
                        end else begin
                            w_state = S_IDLE;
                            w_valid = 1'b1;
                            w_out   = w_def;
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt != ZERO) begin
                        w_cnt = r_cnt - ONE;
                        w_out = r_lvl;
                    end else if (r_cont || (r_rem != ZERO)) begin
                        w_state = S_ACTIVE;
                        w_cnt   = r_w - ONE;
                        w_out   = ~r_lvl;
                    end else begin
                        w_state = S_IDLE;
                        w_valid = 1'b1;
                        w_out   = w_def;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_out   = w_def;
                end
            endcase
            if (w_abort) begin
                w_state = S_IDLE;
                w_cnt   = ZERO;
                w_valid = 1'b1;
                w_out   = w_def;
            end else begin
                w_cnt = w_cnt;
            end
        end

        // Channel state, shadows and registered outputs
        always_ff @(posedge io_clk or posedge io_rst) begin
            if (io_rst) begin
                r_state <= S_IDLE;
                r_cnt   <= ZERO;
                r_rem   <= ZERO;
                r_w     <= ZERO;
                r_g     <= ZERO;
                r_cont  <= 1'b0;
                r_lvl   <= 1'b0;
                r_out   <= 1'b0;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_en_d  <= 1'b0;
            end else begin
                r_state <= w_state;
                r_cnt   <= w_cnt;
                r_rem   <= w_rem;
                r_w     <= w_w;
                r_g     <= w_g;
                r_cont  <= w_cont;
                r_lvl   <= w_lvl;
                r_out   <= w_out;
                r_valid <= w_valid;
                r_busy  <= (w_state != S_IDLE);
                r_en_d  <= bus.io_en[g];
            end
        end

        assign bus.io_pulseOut[g] = r_out;
        assign bus.pulse_valid[g] = r_valid;
        assign bus.pulse_busy[g]  = r_busy;
    end
endmodule

// File: tb/tb_pwm_burst_mc.sv
// Directed bench for pwm_burst_mc: per-cycle expectations derived from burst timing formulas, queued then compared.
module tb_pwm_burst_mc;
    localparam int RW = 32;
    localparam int CH = 4;
`ifdef PWM_TRIG_DELAY_EN
    localparam int D_EFF = 1;
`else
    localparam int D_EFF = 0;
`endif

    typedef struct {
        string         tag;
        logic [CH-1:0] out;
        logic [CH-1:0] valid;
        logic [CH-1:0] busy;
    } exp_t;

    logic io_clk = 1'b0;
    logic io_rst;

    pwm_burst_mc_if #(._RAM_WIDTH(RW), ._CH_NUM(CH)) bus ();
    pwm_burst_mc #(._RAM_WIDTH(RW), ._CH_NUM(CH)) dut (
        .io_clk (io_clk),
        .io_rst (io_rst),
        .bus    (bus)
    );

    always #5 io_clk = ~io_clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_edge   = 0;
    exp_t sb[$];
    int   c_s[CH], c_w[CH], c_g[CH], c_n[CH], c_d[CH], c_a[CH];
    logic c_on[CH];
    logic c_def[CH];

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected channel outputs after edge n, from start edge, delay, period and burst length
    function automatic void exp_ch(input int ch, input int n, output logic o, output logic v, output logic b);
        int rel;
        int per;
        int len;
        o = c_def[ch];
        v = 1'b0;
        b = 1'b0;
        if (c_on[ch] && n >= c_s[ch]) begin
            rel = n - c_s[ch] + 1;
            per = c_w[ch] + c_g[ch];
            len = c_d[ch] + c_n[ch] * per;
            if (c_a[ch] >= 0 && n >= c_a[ch]) begin
                v = (n == c_a[ch]);
            end else if (c_w[ch] == 0) begin
                v = (rel == 1);
            end else if (c_n[ch] != 0 && rel > len) begin
                v = (rel == len + 1);
            end else begin
                b = 1'b1;
                if (rel > c_d[ch] && ((rel - c_d[ch] - 1) % per) < c_w[ch]) o = ~c_def[ch];
            end
        end
    endfunction

    task automatic push_window(input string tag, input int n0, input int n1);
        exp_t e;
        logic o, v, b;
        for (int n = n0; n <= n1; n++) begin
            e.tag = $sformatf("%s@%0d", tag, n);
            for (int ch = 0; ch < CH; ch++) begin
                exp_ch(ch, n, o, v, b);
                e.out[ch]   = o;
                e.valid[ch] = v;
                e.busy[ch]  = b;
            end
            sb.push_back(e);
        end
    endtask

    task automatic step(input int cnt);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            @(posedge io_clk);
            @(negedge io_clk);
            n_edge++;
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_underflow observed=empty expected=entry edge=%0d", n_edge);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, "_out"},   bus.io_pulseOut, e.out);
                chk({e.tag, "_valid"}, bus.pulse_valid, e.valid);
                chk({e.tag, "_busy"},  bus.pulse_busy,  e.busy);
            end
        end
    endtask

    task automatic set_ch(input int ch, input logic dl, input int w, input int g, input int n, input int d);
        c_def[ch] = dl;
        c_w[ch]   = w;
        c_g[ch]   = g;
        c_n[ch]   = n;
        c_d[ch]   = (D_EFF != 0) ? d : 0;
        c_a[ch]   = -1;
        c_on[ch]  = 1'b0;
        c_s[ch]   = 0;
        bus.io_defaultLevel[ch]            = dl;
        bus.io_pulseWidth[ch*RW +: RW]     = w;
        bus.io_unaccessWidth[ch*RW +: RW]  = g;
        bus.io_pusle_times[ch*RW +: RW]    = n;
        bus.io_trigDelay[ch*RW +: RW]      = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        io_rst = 1'b1;
        bus.io_en = '0;
        bus.io_defaultLevel = '0;
        bus.io_pulseWidth = '0;
        bus.io_unaccessWidth = '0;
        bus.io_pusle_times = '0;
        bus.io_trigDelay = '0;
        for (int ch = 0; ch < CH; ch++) set_ch(ch, 1'b0, 0, 0, 0, 0);
        repeat (2) @(negedge io_clk);
        chk("rst_out", bus.io_pulseOut, 4'b0000);
        chk("rst_valid", bus.pulse_valid, 4'b0000);
        chk("rst_busy", bus.pulse_busy, 4'b0000);
        set_ch(1, 1'b1, 0, 0, 0, 0);
        set_ch(2, 1'b1, 0, 0, 0, 0);
        @(negedge io_clk);
        chk("rst_hold_out", bus.io_pulseOut, 4'b0000);
        io_rst = 1'b0;
        n_edge = 0;
        push_window("idle", 1, 3);
        step(3);

        // Two bursts two cycles apart; ch0 width rewritten mid-burst must not matter
        set_ch(0, 1'b0, 3, 2, 4, 0);
        set_ch(1, 1'b1, 2, 3, 3, 0);
        c_s[0] = n_edge + 1; c_on[0] = 1'b1;
        c_s[1] = n_edge + 3; c_on[1] = 1'b1;
        push_window("burst", n_edge + 1, n_edge + 25);
        bus.io_en[0] = 1'b1;
        step(2);
        bus.io_en[1] = 1'b1;
        step(2);
        bus.io_pulseWidth[0 +: RW] = 32'd7;
        step(21);
        bus.io_en[1:0] = 2'b00;
        c_on[0] = 1'b0; c_on[1] = 1'b0;
        push_window("fall_idle", n_edge + 1, n_edge + 2);
        step(2);

        // Continuous train, then abort
        set_ch(1, 1'b1, 1, 0, 0, 0);
        c_s[1] = n_edge + 1; c_a[1] = n_edge + 11; c_on[1] = 1'b1;
        push_window("cont", n_edge + 1, n_edge + 13);
        bus.io_en[1] = 1'b1;
        step(10);
        bus.io_en[1] = 1'b0;
        step(3);
        c_on[1] = 1'b0;

        // W==0 on ch2, zero gap with finite count on ch0
        set_ch(2, 1'b1, 0, 2, 5, 0);
        set_ch(0, 1'b0, 2, 0, 2, 0);
        c_s[0] = n_edge + 1; c_on[0] = 1'b1;
        c_s[2] = n_edge + 1; c_on[2] = 1'b1;
        push_window("w0_g0", n_edge + 1, n_edge + 8);
        bus.io_en[0] = 1'b1;
        bus.io_en[2] = 1'b1;
        step(8);
        bus.io_en[0] = 1'b0;
        bus.io_en[2] = 1'b0;
        c_on[0] = 1'b0; c_on[2] = 1'b0;
        push_window("w0_idle", n_edge + 1, n_edge + 2);
        step(2);

        // Start delay (effective only when compiled in)
        set_ch(3, 1'b0, 2, 1, 1, 5);
        c_s[3] = n_edge + 1; c_on[3] = 1'b1;
        push_window("delay", n_edge + 1, n_edge + 12);
        bus.io_en[3] = 1'b1;
        step(12);
        bus.io_en[3] = 1'b0;
        c_on[3] = 1'b0;
        push_window("delay_idle", n_edge + 1, n_edge + 1);
        step(1);

        // Reset in the middle of an active pulse
        set_ch(0, 1'b1, 10, 1, 1, 0);
        push_window("def_chg", n_edge + 1, n_edge + 1);
        step(1);
        c_s[0] = n_edge + 1; c_on[0] = 1'b1;
        push_window("pre_rst", n_edge + 1, n_edge + 3);
        bus.io_en[0] = 1'b1;
        step(3);
        #2;
        io_rst = 1'b1;
        #1;
        chk("rst_async_out", bus.io_pulseOut, 4'b0000);
        chk("rst_async_valid", bus.pulse_valid, 4'b0000);
        chk("rst_async_busy", bus.pulse_busy, 4'b0000);
        bus.io_en = '0;
        c_on[0] = 1'b0;
        @(negedge io_clk);
        chk("rst_held_out", bus.io_pulseOut, 4'b0000);
        io_rst = 1'b0;
        push_window("post_rst", n_edge + 1, n_edge + 4);
        step(4);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
